nes_poll_scheduler: RTL
=======================

// Module: nes_poll_scheduler
// PURPOSE
//  Polls two NES pads that share one latch line and one data-clock line.
//  Each pad has its own serial data input.
//  Generates registered, glitch-free latch and clock waveforms at a programmable rate.
//  Deserialises both pads in parallel and publishes debounced-by-frame button vectors.
//  Also publishes per-frame new-press events for game/UI logic.
//  Polls are triggered by a periodic tick or an on-demand request.
// PARAMETERS
//  HALF_CYCLES    300     clk cycles per nes_clk half-period; must be >=4
//  LATCH_CYCLES   600     clk cycles nes_latch is held high; must be >=4
//  POLL_CYCLES    833333  period of the poll tick in clk cycles (60 Hz at 50 MHz); must be >=2
// PORTS
//  clk            in   1  system clock; sole clock domain
//  reset_n        in   1  asynchronous, active-low reset
//  enable         in   1  1 = periodic tick may set pending; 0 = tick ignored
//  poll_req       in   1  1-cycle pulse: request one poll now (works regardless of enable)
//  nes_data       in   2  serial data from pad0 [0] / pad1 [1]; active-low, asynchronous
//  nes_latch      out  1  shared latch to both pads, registered
//  nes_clk        out  1  shared data clock to both pads, registered; idles low
//  pad0_buttons   out  8  active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  pad1_buttons   out  8  same bit order as pad0_buttons
//  pad0_pressed   out  8  bits that went 0->1 this frame; valid only while frame_valid=1
//  pad1_pressed   out  8  same rule as pad0_pressed, for pad1
//  frame_valid    out  1  1-cycle pulse: button/pressed outputs updated this cycle
//  busy           out  1  1 from the first LATCH cycle through the DONE cycle
// BEHAVIOUR
//  Reset (async assert, sync release): every output 0; FSM=IDLE; tick counter=0; pending=0.
//  Reset (cont.): synchroniser flops and shift registers cleared.
//  nes_data passes through a 2-flop synchroniser before any sampling.
//  Tick counter free-runs 0..POLL_CYCLES-1; wrap to 0 is a tick.
//  Pending flag: set by (tick & enable) or poll_req; cleared in the cycle the FSM enters LATCH.
//  Set wins over clear when both happen in the same cycle.
//  A request arriving while busy is held as a single pending poll; multiple requests collapse.
//  FSM states and transitions (phase counter reloads on every state entry):
//   IDLE : latch=0, clk=0. If pending, go to LATCH next cycle.
//   LATCH: nes_latch=1 for LATCH_CYCLES, then go to GAP.
//   GAP  : latch=0, clk=0 for HALF_CYCLES. On the last cycle, sample bit0 (A) of both pads.
//   HIGH : nes_clk=1 for HALF_CYCLES, then go to LOW.
//   LOW  : nes_clk=0 for HALF_CYCLES. On the last cycle, sample bit n (n=1..7).
//          After bit 7 is sampled, go to DONE; otherwise go to HIGH.
//   DONE : 1 cycle, then go to IDLE.
//          pad*_buttons <= ~sampled bits; pad*_pressed = new & ~old; frame_valid=1.
//  Latency: first latch-high cycle to frame_valid = LATCH+HALF+14*HALF cycles.
//  The same latency gives exactly 7 nes_clk rising edges per poll.
//  Pending set during a poll: next LATCH starts 1 cycle after DONE (IDLE lasts 1 cycle).
//  enable=0 mid-poll: the current poll completes normally; only new ticks are blocked.
//  Reset mid-poll: lines drop low immediately; the partial frame is discarded.
//  Buttons hold their last value between frames; pressed outputs are 0 outside frame_valid.
// TESTING
//  Bench parameters: HALF=4, LATCH=8, POLL=200.
//  Pad model: 8-bit shift register per pad.
//   Parallel load while nes_latch=1; shifts on nes_clk rising edge.
//   Drives active-low data, A first.
//  1 reset: hold reset_n=0 with pads pressed.
//    -> all outputs 0, nes_latch=0, nes_clk=0, no frame_valid.
//  2 single poll: enable=0; pad0 A+Start, pad1 Right; poll_req pulse.
//    -> latch high 8 cycles, then 7 clk pulses of 4H/4L.
//    -> frame_valid 68 cycles after latch rise.
//    -> pad0_buttons=0x09, pad1_buttons=0x80, pad0_pressed=0x09, pad1_pressed=0x80.
//  3 periodic: enable=1, buttons constant.
//    -> frame_valid every 200 cycles; 2nd frame pressed=0x00, buttons unchanged.
//  4 back-to-back: poll_req pulsed twice while busy.
//    -> exactly one extra poll; its LATCH starts 2 cycles after the prior frame_valid.
//  5 reset mid-poll during bit-3 HIGH.
//    -> nes_clk/latch low same cycle, buttons=0x00.
//    -> after release, no poll until tick or req.
//  6 enable->0 during LOW of bit 5.
//    -> frame completes with correct data; then no frame_valid for 1000 cycles.

Source files
------------

// File: rtl/nes_poll_scheduler.sv
// Polls two NES pads over a shared latch/clock pair and publishes per-frame button state.
module nes_poll_scheduler #(
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       poll_req,
  input  logic [1:0] nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] pad0_buttons,
  output logic [7:0] pad1_buttons,
  output logic [7:0] pad0_pressed,
  output logic [7:0] pad1_pressed,
  output logic       frame_valid,
  output logic       busy
);

  localparam int unsigned PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX);
  localparam int unsigned TK_W   = $clog2(POLL_CYCLES);

  localparam logic [PH_W-1:0] LATCH_LOAD = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0] HALF_LOAD  = PH_W'(HALF_CYCLES - 1);
  localparam logic [TK_W-1:0] TICK_LAST  = TK_W'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_GAP   = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic [2:0]      bit_idx, bit_nxt;
  logic [TK_W-1:0] tick_cnt;
  logic            pending;
  logic [1:0]      data_meta, data_sync;
  logic [6:0]      shift0, shift1;
  logic            shift_en, done_en, tick, pend_set, pend_clr, last;

  assign tick     = (tick_cnt == TICK_LAST);
  assign pend_set = (tick & enable) | poll_req;
  assign pend_clr = (state == S_IDLE) & pending;
  assign last     = (phase == '0);

  // Two-flop synchroniser for the asynchronous pad data lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      data_meta <= nes_data;
      data_sync <= data_meta;
    end
  end

  // Free-running poll tick counter and the single-entry pending request flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      pending  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TK_W'(1);
      pending  <= pend_set | (pending & ~pend_clr);
    end
  end

  // State, phase and bit-index registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      bit_idx <= bit_nxt;
    end
  end

  // Next-state logic; phase reloads on every state entry and counts down to zero
  always_comb begin
    state_nxt = state;
    phase_nxt = last ? '0 : phase - PH_W'(1);
    bit_nxt   = bit_idx;
    shift_en  = 1'b0;
    done_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending) begin
          state_nxt = S_LATCH;
          phase_nxt = LATCH_LOAD;
          bit_nxt   = 3'd0;
        end
      end
      S_LATCH: begin
        if (last) begin
          state_nxt = S_GAP;
          phase_nxt = HALF_LOAD;
        end
      end
      S_GAP: begin
        if (last) begin
          shift_en  = 1'b1;
          state_nxt = S_HIGH;
          phase_nxt = HALF_LOAD;
          bit_nxt   = 3'd1;
        end
      end
      S_HIGH: begin
        if (last) begin
          state_nxt = S_LOW;
          phase_nxt = HALF_LOAD;
        end
      end
      S_LOW: begin
        if (last) begin
          if (bit_idx == 3'd7) begin
            done_en   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            shift_en  = 1'b1;
            state_nxt = S_HIGH;
            phase_nxt = HALF_LOAD;
            bit_nxt   = bit_idx + 3'd1;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bits 0..6 shift in from the top so bit 0 lands in the LSB after seven samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift0 <= '0;
      shift1 <= '0;
    end else if (shift_en) begin
      shift0 <= {data_sync[0], shift0[6:1]};
      shift1 <= {data_sync[1], shift1[6:1]};
    end
  end

  // Registered pad lines, status and per-frame outputs aligned with the DONE cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nes_latch    <= 1'b0;
      nes_clk      <= 1'b0;
      busy         <= 1'b0;
      frame_valid  <= 1'b0;
      pad0_buttons <= '0;
      pad1_buttons <= '0;
      pad0_pressed <= '0;
      pad1_pressed <= '0;
    end else begin
      nes_latch   <= (state_nxt == S_LATCH);
      nes_clk     <= (state_nxt == S_HIGH);
      busy        <= (state_nxt != S_IDLE);
      frame_valid <= done_en;
      if (done_en) begin
        pad0_buttons <= ~{data_sync[0], shift0};
        pad1_buttons <= ~{data_sync[1], shift1};
        pad0_pressed <= ~{data_sync[0], shift0} & ~pad0_buttons;
        pad1_pressed <= ~{data_sync[1], shift1} & ~pad1_buttons;
      end else begin
        pad0_pressed <= '0;
        pad1_pressed <= '0;
      end
    end
  end

endmodule
